// File: rtl/op_sram_arb_if.sv
// Requester-side bundle for the OP SRAM arbiter: per-requester request, grant and read-return signals.
// Requester i occupies bit i of the vectors and slice [i*AW +: AW] / [i*DW +: DW] of the packed buses.
interface op_sram_arb_if #(
    parameter int NREQ = 3,
    parameter int DW   = 128,
    parameter int AW   = 9
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_d;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_wen, req_lock, req_addr, req_d,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_wen, req_lock, req_addr, req_d,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/op_sram_arb.sv
// Round-robin arbiter with burst lock sharing the single-port OP SRAM; optional counters under OP_ARB_STATS_EN.
// Latency: grant is same-cycle combinational, read data returns one cycle after the grant.
// Backpressure: a requester simply waits with valid high until req_ready; a lock owner stalls all others.
module op_sram_arb #(
    parameter int NREQ     = 3,
    parameter int DW       = 128,
    parameter int AW       = 9,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    op_sram_arb_if.slave      bus,
    input  logic [DW-1:0]     OP_q,
    output logic [DW-1:0]     OP_d,
    output logic [AW-1:0]     OP_addr,
    output logic              OP_cen,
    output logic              OP_wen
`ifdef OP_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [NREQ*16-1:0] stat_grant,
    output logic [NREQ*16-1:0] stat_stall
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    localparam logic [0:0] ST_FREE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    r_state;
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] r_lock_owner;
    logic [CW-1:0] r_lock_cnt;
    logic          r_rd_pend;
    logic [PW-1:0] r_rd_tag;

    logic            w_own_hold;
    logic            w_gnt_any;
    logic [PW-1:0]   w_gnt_idx;
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_next_ptr;
    logic            w_gnt_rd;
    int              w_idx;

    // Owner keeps the SRAM while valid; otherwise the cycle falls through to round-robin.
    always_comb begin
        w_gnt      = '0;
        w_gnt_idx  = '0;
        w_gnt_any  = 1'b0;
        w_idx      = 0;
        w_own_hold = reset_n && (r_state == ST_LOCKED) && bus.req_valid[r_lock_owner];
        if (!reset_n) begin
            w_gnt_any = 1'b0;
        end else if (w_own_hold) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = r_lock_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = (int'(r_rr_ptr) + k) % NREQ;
                if (!w_gnt_any && bus.req_valid[w_idx]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = PW'(w_idx);
                end
            end
        end
        if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
    end

    assign w_next_ptr    = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_rd      = w_gnt_any && !bus.req_wen[w_gnt_idx];
    assign bus.req_ready = w_gnt;

    assign OP_cen  = !w_gnt_any;
    assign OP_wen  = w_gnt_any ? !bus.req_wen[w_gnt_idx] : 1'b1;
    assign OP_addr = w_gnt_any ? bus.req_addr[int'(w_gnt_idx)*AW +: AW] : '0;
    assign OP_d    = w_gnt_any ? bus.req_d[int'(w_gnt_idx)*DW +: DW] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_FREE;
            r_rr_ptr     <= '0;
            r_lock_owner <= '0;
            r_lock_cnt   <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_tag     <= '0;
        end else begin
            r_rd_pend <= w_gnt_rd;
            if (w_gnt_rd) r_rd_tag <= w_gnt_idx;

            if (w_own_hold) begin
                r_rr_ptr <= w_next_ptr;
                // Reaching MAX_LOCK hands the next cycle to round-robin, which already points past the owner.
                if (!bus.req_lock[r_lock_owner] || (r_lock_cnt >= CW'(MAX_LOCK - 1))) begin
                    r_state    <= ST_FREE;
                    r_lock_cnt <= '0;
                end else begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end
            end else if (w_gnt_any) begin
                r_rr_ptr     <= w_next_ptr;
                r_lock_owner <= w_gnt_idx;
                if (bus.req_lock[w_gnt_idx] && (MAX_LOCK > 1)) begin
                    r_state    <= ST_LOCKED;
                    r_lock_cnt <= CW'(1);
                end else begin
                    r_state    <= ST_FREE;
                    r_lock_cnt <= '0;
                end
            end else begin
                r_state    <= ST_FREE;
                r_lock_cnt <= '0;
            end
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (r_rd_pend) bus.rsp_valid[r_rd_tag] = 1'b1;
    end
    assign bus.rsp_data = r_rd_pend ? OP_q : '0;

`ifdef OP_ARB_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        logic [15:0] r_grant_cnt;
        logic [15:0] r_stall_cnt;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_grant_cnt <= '0;
                r_stall_cnt <= '0;
            end else if (stat_clr) begin
                r_grant_cnt <= '0;
                r_stall_cnt <= '0;
            end else begin
                if (w_gnt[gi] && (r_grant_cnt != 16'hFFFF))
                    r_grant_cnt <= r_grant_cnt + 16'd1;
                if (bus.req_valid[gi] && !w_gnt[gi] && (r_stall_cnt != 16'hFFFF))
                    r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
        assign stat_grant[gi*16 +: 16] = r_grant_cnt;
        assign stat_stall[gi*16 +: 16] = r_stall_cnt;
    end
`endif
endmodule

// File: tb/tb_op_sram_arb.sv
// Directed plus randomized bench for op_sram_arb against a rotation/burst reference model and a reference memory.
module tb_op_sram_arb;
    localparam int NREQ = 3;
    localparam int DW   = 128;
    localparam int AW   = 9;
    localparam int MAXL = 16;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] OP_q;
    logic [DW-1:0] OP_d;
    logic [AW-1:0] OP_addr;
    logic          OP_cen;
    logic          OP_wen;

    op_sram_arb_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    op_sram_arb #(.NREQ(NREQ), .DW(DW), .AW(AW), .MAX_LOCK(MAXL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .OP_q    (OP_q),
        .OP_d    (OP_d),
        .OP_addr (OP_addr),
        .OP_cen  (OP_cen),
        .OP_wen  (OP_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro stand-in driven purely by the DUT pins.
    logic [DW-1:0] sram [512];
    always @(posedge clk) begin
        if (!OP_cen) begin
            if (!OP_wen) sram[OP_addr] <= OP_d;
            else         OP_q <= sram[OP_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [512];
    int            m_next;
    int            m_owner;
    int            m_burst;
    bit            m_pend;
    int            m_tag;
    logic [DW-1:0] m_data;
    bit            want_en;
    logic [2:0]    want_rdy;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_next  = 0;
        m_owner = -1;
        m_burst = 0;
        m_pend  = 0;
        m_tag   = 0;
        m_data  = '0;
    endtask

    function automatic int model_pick();
        if (m_owner >= 0 && bus.req_valid[m_owner]) return m_owner;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_next + k) % NREQ;
            if (bus.req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit vld, input bit w, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]         = vld;
        bus.req_wen[i]           = w;
        bus.req_lock[i]          = lk;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_d[i*DW +: DW]    = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, '0, '0);
    endtask

    // One clock: check combinational outputs at negedge, then advance the model at the posedge.
    task automatic cycle();
        int            g;
        logic [2:0]    er;
        logic [2:0]    ev;
        logic [AW-1:0] ga;
        @(negedge clk);
        g  = model_pick();
        er = (g >= 0) ? 3'(1 << g) : 3'b000;
        ev = m_pend ? 3'(1 << m_tag) : 3'b000;
        chk("req_ready", bus.req_ready, er);
        chk("op_cen", OP_cen, (g < 0));
        if (g >= 0) begin
            chk("op_wen", OP_wen, !bus.req_wen[g]);
            chk("op_addr", OP_addr, bus.req_addr[g*AW +: AW]);
            chk("op_d", OP_d, bus.req_d[g*DW +: DW]);
        end
        chk("rsp_valid", bus.rsp_valid, ev);
        chk("rsp_data", bus.rsp_data, m_pend ? m_data : '0);
        if (want_en) chk("directed_ready", bus.req_ready, want_rdy);
        @(posedge clk);
        m_pend = (g >= 0) && !bus.req_wen[g];
        if (g >= 0) begin
            ga = bus.req_addr[g*AW +: AW];
            if (m_pend) begin
                m_tag  = g;
                m_data = ref_mem[ga];
            end else begin
                ref_mem[ga] = bus.req_d[g*DW +: DW];
            end
            if (g == m_owner) begin
                m_burst++;
                if (!bus.req_lock[g] || m_burst >= MAXL) m_owner = -1;
            end else begin
                m_owner = bus.req_lock[g] ? g : -1;
                m_burst = 1;
            end
            m_next = (g + 1) % NREQ;
        end else begin
            m_owner = -1;
        end
        #1;
    endtask

    task automatic rand_phase(input int n, input int lock_pct);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 99) < lock_pct, AW'($urandom_range(0, 7)),
                        {$urandom, $urandom, $urandom, $urandom});
            cycle();
        end
    endtask

    initial begin
        logic [DW-1:0] pat_a5;
        pat_a5 = {16{8'hA5}};
        for (int i = 0; i < 512; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        OP_q    = '0;
        want_en = 0;
        want_rdy = '0;
        model_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, AW'(i), '0);

        // Reset with every requester valid
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 3'b000);
        chk("rst_cen", OP_cen, 1'b1);
        chk("rst_wen", OP_wen, 1'b1);
        chk("rst_addr", OP_addr, '0);
        chk("rst_d", OP_d, '0);
        chk("rst_rsp_valid", bus.rsp_valid, 3'b000);
        reset_n = 1'b1;

        // Continuous requests rotate 0,1,2,0,1,2
        want_en = 1;
        for (int i = 0; i < 6; i++) begin
            want_rdy = 3'(1 << (i % 3));
            cycle();
        end

        // Write then read the same address
        clear_reqs();
        set_req(0, 1, 1, 0, 9'h05, pat_a5);
        want_rdy = 3'b001;
        cycle();
        clear_reqs();
        set_req(2, 1, 0, 0, 9'h05, '0);
        want_rdy = 3'b100;
        cycle();
        chk("wr_rd_valid", bus.rsp_valid, 3'b100);
        chk("wr_rd_data", bus.rsp_data, pat_a5);
        clear_reqs();
        want_rdy = 3'b000;
        cycle();

        // Burst lock capped at MAX_LOCK grants
        set_req(1, 1, 1, 1, 9'h10, {4{32'h1111_0000}});
        want_rdy = 3'b010;
        cycle();
        set_req(0, 1, 0, 0, 9'h01, '0);
        set_req(2, 1, 0, 0, 9'h02, '0);
        for (int i = 1; i < MAXL; i++) cycle();
        set_req(1, 0, 0, 0, '0, '0);
        want_rdy = 3'b100;
        cycle();
        want_rdy = 3'b001;
        cycle();

        // Owner drops valid mid-burst: released the same cycle
        clear_reqs();
        set_req(0, 1, 1, 1, 9'h20, {4{32'h2020_2020}});
        want_rdy = 3'b001;
        cycle();
        set_req(1, 1, 1, 0, 9'h21, {4{32'h2121_2121}});
        want_rdy = 3'b001;
        cycle();
        set_req(0, 0, 0, 0, '0, '0);
        want_rdy = 3'b010;
        cycle();
        set_req(0, 1, 0, 0, 9'h20, '0);
        set_req(1, 0, 0, 0, '0, '0);
        want_rdy = 3'b001;
        cycle();

        // Back-to-back reads from different requesters
        clear_reqs();
        sram[3] = {4{32'h0303_0303}};  ref_mem[3] = {4{32'h0303_0303}};
        sram[4] = {4{32'h0404_0404}};  ref_mem[4] = {4{32'h0404_0404}};
        set_req(1, 1, 0, 0, 9'h03, '0);
        want_rdy = 3'b010;
        cycle();
        chk("b2b_first", bus.rsp_valid, 3'b010);
        clear_reqs();
        set_req(2, 1, 0, 0, 9'h04, '0);
        want_rdy = 3'b100;
        cycle();
        chk("b2b_second", bus.rsp_valid, 3'b100);
        chk("b2b_second_data", bus.rsp_data, {4{32'h0404_0404}});
        clear_reqs();
        want_rdy = 3'b000;
        cycle();

        // Reset between a read grant and its response
        set_req(1, 1, 0, 0, 9'h03, '0);
        want_rdy = 3'b010;
        cycle();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", bus.rsp_valid, 3'b000);
        chk("mid_rst_rsp_data", bus.rsp_data, '0);
        chk("mid_rst_cen", OP_cen, 1'b1);
        chk("mid_rst_ready", bus.req_ready, 3'b000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        want_en = 0;

        rand_phase(200, 25);
        rand_phase(200, 90);
        clear_reqs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/op_sram_arb.md
Name: op_sram_arb

Overview:
- Arbiter sharing the single-port output/psum SRAM (128-bit words, 9-bit address) between three requesters.
  - Requester 0: OFIFO psum writeback.
  - Requester 1: SFU accumulate read/write.
  - Requester 2: host/testbench final readout.
- At most one SRAM access per cycle.
- Routes 1-cycle-latency read data back to the requester that issued the read.
- Sits between the corelet datapath and the OP SRAM macro; it replaces direct OP_* driving by the corelet sequencer.

Parameters:
- NREQ, 3, number of requesters (fixed at 3 for this revision).
- DW, 128, SRAM data width (col*psum_bw).
- AW, 9, SRAM address width.
- MAX_LOCK, 16, maximum consecutive cycles one requester may hold the SRAM using lock.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous reset, active-low.
- req_valid  in  NREQ  per-requester access request.
- req_wen  in  NREQ  per-requester access type: 1 = write, 0 = read.
- req_lock  in  NREQ  request to keep the grant next cycle (burst).
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_d  in  NREQ*DW  packed write data.
- req_ready  out  NREQ  one-hot grant; the access is accepted this cycle.
- rsp_valid  out  NREQ  one-hot; read data is valid for requester i.
- rsp_data  out  DW  read data, shared by all requesters.
- OP_q  in  DW  SRAM read data.
- OP_d  out  DW  SRAM write data.
- OP_addr  out  AW  SRAM address.
- OP_cen  out  1  SRAM chip enable, active-low.
- OP_wen  out  1  SRAM write enable, active-low.

Behaviour:
- Reset state (while reset_n low):
  - req_ready = 0, rsp_valid = 0.
  - OP_cen = 1, OP_wen = 1, OP_addr = 0, OP_d = 0.
  - rr_ptr = 0, lock_owner = none, lock_cnt = 0.
- Grant timing:
  - Grant is combinational from req_valid and registered state (same-cycle ready).
  - Handshake: an access completes in the cycle where req_valid[i] and req_ready[i] are both 1.
  - req_ready[i] is never 1 when req_valid[i] is 0.
- SRAM drive: for granted i, OP_cen = 0, OP_wen = !req_wen[i], OP_addr = req_addr[i], OP_d = req_d[i]. With no grant, OP_cen = 1 and OP_wen = 1.
- Arbitration states:
  - FREE:
    - Round-robin: search starts at rr_ptr and wraps NREQ-1 -> 0.
    - On a grant to i, rr_ptr <= (i+1) mod NREQ.
    - If req_lock[i] is set on the granted cycle, go to LOCKED with lock_owner = i and lock_cnt = 1.
  - LOCKED:
    - Owner i is granted whenever req_valid[i] is 1; others are stalled.
    - lock_cnt increments on each granted owner cycle.
    - Return to FREE when any of these holds:
      - req_lock[i] deasserts on a granted cycle;
      - req_valid[i] = 0 (the cycle is released to the round-robin search the same cycle);
      - lock_cnt reaches MAX_LOCK (the next cycle is arbitrated in FREE with rr_ptr already past i).
- Read return:
  - A granted read sets rd_tag <= i, rd_pend <= 1.
  - Next cycle: rsp_valid[rd_tag] = 1 and rsp_data = OP_q.
  - rsp_data is 0 when no response is pending.
  - Back-to-back reads from different requesters each return exactly 1 cycle after their grant, in grant order.
  - A write-then-read to the same address on consecutive cycles returns the newly written data (SRAM ordering; no forwarding logic).
- Simultaneous events:
  - A request arriving in the same cycle a lock releases competes in the round-robin.
  - All three valid in FREE with rr_ptr = 0 gives the grant order 0, 1, 2, 0, ...
- Reset mid-operation:
  - Any pending rsp_valid is dropped.
  - The lock is cleared.
  - OP_cen = 1 within the reset cycle (asynchronous).
- Address and data pass through unmodified; no width conversion.

Optional Feature:
- Macro: OP_ARB_STATS_EN
- With the macro defined:
  - Adds output stat_grant (NREQ*16): per-requester saturating counters of completed accesses.
  - Adds output stat_stall (NREQ*16): per-requester saturating counters of cycles with valid=1 and ready=0.
  - Adds input stat_clr: synchronous clear of all counters.
  - Counters reset to 0 and saturate at 16'hFFFF.
- Without the macro: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset with all req_valid = 1 -> req_ready = 000, OP_cen = 1, OP_wen = 1. After release, first grant is req0 and rr_ptr becomes 1.
- All three request continuously, no lock, 6 cycles -> grants 0, 1, 2, 0, 1, 2; OP_cen = 0 every cycle.
- req2 reads addr 9'h05 after req0 wrote 128'hA5.. to 9'h05 the prior cycle -> rsp_valid = 100 one cycle after the grant, rsp_data = 128'hA5...
- req1 holds lock with MAX_LOCK = 16 while req0 and req2 request -> req1 granted 16 consecutive cycles, then req2 granted (rr_ptr = 2), then req0.
- req0 locked and drops valid mid-burst while req1 is valid -> req1 granted in that same cycle; state returns to FREE.
- Reads from req1 then req2 back-to-back at addrs 3, 4 -> rsp_valid 010 then 100 on consecutive cycles with OP_q data. Asserting reset_n = 0 between the grant and its response -> no rsp_valid.
